// File: rtl/scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_mux_pkg
// Description : Shared mode encodings, counter width and clog2 helper for
//               the scan_mux block.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DWELL_W = 16;

    // Ceiling log2 with a floor of 1 so a 2-channel mux still gets a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : scan_counter
// Description : Scan channel / dwell counter with one-cycle wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_counter
    import scan_mux_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int DWELL = 1,
    localparam int SW    = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    output logic [SW-1:0] ch,
    output logic          wrap
);

    localparam logic [SW-1:0]      c_last_ch = SW'(N - 1);
    localparam logic [DWELL_W-1:0] c_last_dc = DWELL_W'(DWELL - 1);

    logic [SW-1:0]      r_ch;
    logic [DWELL_W-1:0] r_dc;
    logic               r_wrap;
    logic               w_dwell_done;

    assign w_dwell_done = (r_dc == c_last_dc);

    // wrap is held while disabled so a gated cycle cannot swallow the pulse.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_ch   <= '0;
            r_dc   <= '0;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_wrap <= w_dwell_done && (r_ch == c_last_ch);
            if (w_dwell_done) begin
                r_dc <= '0;
                r_ch <= (r_ch == c_last_ch) ? '0 : r_ch + 1'b1;
            end else begin
                r_dc <= r_dc + 1'b1;
            end
        end
    end

    assign ch   = r_ch;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : scan_mux
// Description : N-channel W-bit registered mux with manual select and
//               auto-scan modes, range checking and frame-done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 1,
    localparam int SW    = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    output logic           sel_err,
    output logic           frame_done
);

    logic          r_mode_q;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_ch;
    logic          r_out_valid;
    logic          r_sel_err;
    logic          r_frame_done;

    logic          w_mode_chg;
    logic          w_scan;
    logic          w_in_range;
    logic [SW-1:0] w_ch;
    logic          w_wrap;
    logic [SW-1:0] w_idx;
    logic [W-1:0]  w_data;

    assign w_scan     = (mode == MODE_SCAN);
    assign w_mode_chg = (mode != r_mode_q);
    assign w_in_range = (32'(sel) < 32'(N));
    assign w_idx      = w_scan ? w_ch : sel;

    scan_counter #(
        .N     (N),
        .DWELL (DWELL)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (en & w_scan),
        .clear (en & w_mode_chg),
        .ch    (w_ch),
        .wrap  (w_wrap)
    );

    // Only legal indices are decoded; an out-of-range select yields zero.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_idx == SW'(k)) begin
                w_data = in_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q     <= MODE_MANUAL;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_out_valid  <= 1'b0;
            r_sel_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_frame_done <= 1'b0;
        end else begin
            r_mode_q     <= mode;
            r_out_data   <= w_data;
            r_out_ch     <= w_idx;
            r_out_valid  <= w_scan | w_in_range;
            r_sel_err    <= ~w_scan & ~w_in_range;
            r_frame_done <= w_scan & w_wrap & ~w_mode_chg;
        end
    end

    assign out_data   = r_out_data;
    assign out_ch     = r_out_ch;
    assign out_valid  = r_out_valid;
    assign sel_err    = r_sel_err;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_mux
// Description : Scoreboard bench for scan_mux: two instances (N=8/W=1/DWELL=3
//               and N=6/W=8/DWELL=2) against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux;

    typedef struct packed {
        logic [63:0] od;
        logic [31:0] oc;
        logic        ov;
        logic        er;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        mode_a, mode_b;
    logic [2:0]  sel_a, sel_b;
    logic [7:0]  in_a;
    logic [47:0] in_b;

    logic [0:0]  od_a;
    logic [2:0]  oc_a;
    logic        ov_a, er_a, fd_a;
    logic [7:0]  od_b;
    logic [2:0]  oc_b;
    logic        ov_b, er_b, fd_b;

    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_ch [2];
    int   m_dc [2];
    logic m_wrap [2];
    logic m_mq [2];
    exp_t m_out [2];
    exp_t qa [$];
    exp_t qb [$];

    always #5 clk = ~clk;

    scan_mux #(.N(8), .W(1), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode_a), .sel(sel_a), .in_data(in_a),
        .out_data(od_a), .out_ch(oc_a), .out_valid(ov_a), .sel_err(er_a), .frame_done(fd_a)
    );

    scan_mux #(.N(6), .W(8), .DWELL(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode_b), .sel(sel_b), .in_data(in_b),
        .out_data(od_b), .out_ch(oc_b), .out_valid(ov_b), .sel_err(er_b), .frame_done(fd_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] chan(input logic [63:0] din, input int k, input int w);
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (din >> (k * w)) & m;
    endfunction

    // Behavioural model of one edge; result pushed as the expected post-edge outputs.
    task automatic model(input int id, input int n, input int dw, input int w,
                         input logic md, input int sl, input logic [63:0] din);
        exp_t o;
        logic chg;
        o = m_out[id];
        if (rst) begin
            o = '0;
            m_ch[id] = 0; m_dc[id] = 0; m_wrap[id] = 1'b0; m_mq[id] = 1'b0;
        end else if (!en) begin
            o.fd = 1'b0;
        end else begin
            chg = (md != m_mq[id]);
            m_mq[id] = md;
            if (!md) begin
                o.oc = 32'(sl);
                o.fd = 1'b0;
                if (sl < n) begin
                    o.od = chan(din, sl, w); o.ov = 1'b1; o.er = 1'b0;
                end else begin
                    o.od = '0; o.ov = 1'b0; o.er = 1'b1;
                end
                m_ch[id] = 0; m_dc[id] = 0; m_wrap[id] = 1'b0;
            end else begin
                o.od = chan(din, m_ch[id], w);
                o.oc = 32'(m_ch[id]);
                o.ov = 1'b1; o.er = 1'b0;
                o.fd = m_wrap[id] && !chg;
                m_wrap[id] = 1'b0;
                if (chg) begin
                    m_ch[id] = 0; m_dc[id] = 0;
                end else if (m_dc[id] == dw - 1) begin
                    m_dc[id] = 0;
                    if (m_ch[id] == n - 1) begin
                        m_ch[id] = 0; m_wrap[id] = 1'b1;
                    end else begin
                        m_ch[id] = m_ch[id] + 1;
                    end
                end else begin
                    m_dc[id] = m_dc[id] + 1;
                end
            end
        end
        m_out[id] = o;
        if (id == 0) qa.push_back(o);
        else         qb.push_back(o);
    endtask

    task automatic tick();
        exp_t e;
        model(0, 8, 3, 1, mode_a, int'(sel_a), 64'(in_a));
        model(1, 6, 2, 8, mode_b, int'(sel_b), 64'(in_b));
        @(posedge clk);
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("a.out_data",   64'(od_a), e.od);
            check("a.out_ch",     64'(oc_a), 64'(e.oc));
            check("a.out_valid",  64'(ov_a), 64'(e.ov));
            check("a.sel_err",    64'(er_a), 64'(e.er));
            check("a.frame_done", 64'(fd_a), 64'(e.fd));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("b.out_data",   64'(od_b), e.od);
            check("b.out_ch",     64'(oc_b), 64'(e.oc));
            check("b.out_valid",  64'(ov_b), 64'(e.ov));
            check("b.sel_err",    64'(er_b), 64'(e.er));
            check("b.frame_done", 64'(fd_b), 64'(e.fd));
        end
    endtask

    initial begin
        int c_seq [8];
        int first;
        int period;
        int hit;
        c_seq = '{1, 0, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i < 2; i++) begin
            m_ch[i] = 0; m_dc[i] = 0; m_wrap[i] = 1'b0; m_mq[i] = 1'b0; m_out[i] = '0;
        end

        rst = 1'b1; en = 1'b1; mode_a = 1'b0; mode_b = 1'b0;
        sel_a = 3'd0; sel_b = 3'd0;
        in_a = 8'b1011_0001;
        in_b = 48'hA5_3C_96_0F_E1_7B;
        tick();
        tick();
        check("rst.a.out_valid", 64'(ov_a), 64'd0);
        check("rst.b.out_data",  64'(od_b), 64'd0);
        rst = 1'b0;

        // Manual sweep on the 8-channel instance.
        for (int k = 0; k < 8; k++) begin
            sel_a = 3'(k);
            tick();
            check("man.seq", 64'(od_a), 64'(c_seq[k]));
            check("man.valid", 64'(ov_a), 64'd1);
        end

        // Out-of-range select on the 6-channel instance, then a legal one.
        sel_b = 3'd7;
        tick();
        check("oor.sel_err",   64'(er_b), 64'd1);
        check("oor.out_valid", 64'(ov_b), 64'd0);
        check("oor.out_data",  64'(od_b), 64'd0);
        sel_b = 3'd5;
        tick();
        check("sel5.out_data", 64'(od_b), 64'(in_b[47:40]));
        check("sel5.sel_err",  64'(er_b), 64'd0);

        // Scan entry; frame_done period must be N*DWELL.
        mode_a = 1'b1; mode_b = 1'b1;
        first = -1; period = -1;
        for (int t = 0; t < 100 && period < 0; t++) begin
            tick();
            if (fd_a) begin
                if (first < 0) first = t;
                else           period = t - first;
            end
        end
        check("scan.fd_period", 64'(period), 64'd24);

        // Gate en for three cycles in the middle of a DWELL=2 hold.
        hit = 0;
        for (int t = 0; t < 4 && hit == 0; t++) begin
            if (m_dc[1] == 1) hit = 1;
            else tick();
        end
        check("gap.reached", 64'(hit), 64'd1);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (6) tick();

        // Reset while scanning channel 5.
        hit = 0;
        for (int t = 0; t < 40 && hit == 0; t++) begin
            if (m_ch[0] == 5) hit = 1;
            else tick();
        end
        check("rst5.reached", 64'(hit), 64'd1);
        rst = 1'b1;
        tick();
        check("rst5.out_ch",    64'(oc_a), 64'd0);
        check("rst5.out_data",  64'(od_a), 64'd0);
        check("rst5.out_valid", 64'(ov_a), 64'd0);
        rst = 1'b0;
        repeat (10) tick();

        // Scan -> manual -> scan with the first toggle on a dwell-expiry edge.
        hit = 0;
        for (int t = 0; t < 6 && hit == 0; t++) begin
            if (m_dc[0] == 2) hit = 1;
            else tick();
        end
        check("tog.reached", 64'(hit), 64'd1);
        mode_a = 1'b0;
        tick();
        mode_a = 1'b1;
        tick();
        repeat (30) tick();

        // Random traffic: gating, mode flips, illegal selects, rare resets.
        for (int t = 0; t < 400; t++) begin
            en    = ($urandom_range(0, 7) != 0);
            rst   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 19) == 0) mode_b = ~mode_b;
            sel_a = 3'($urandom_range(0, 7));
            sel_b = 3'($urandom_range(0, 7));
            in_a  = 8'($urandom);
            in_b  = {16'($urandom), 32'($urandom)};
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
